slice_stream_host: RTL and testbench
====================================

# slice_stream_host

Host-side sequencer for the column-parity function block. It buffers a 64-line × 25-bit state image from an upstream loader and pulses the function's start. It serves `line_in` by the function's line index, captures every `write_value` strobed by `write_enable`, and streams the 64 result lines downstream once the function reports done. It is the opposite end of the function's `start`/`cnt_value`/`line_in`/`write_enable`/`write_value`/`donee` interface.

## Interface

**Parameters**
- LINES, 64, lines per state image (index width 6; function index is 7 bits).
- WIDTH, 25, bits per line.
- TIMEOUT, 1024, maximum RUN cycles without `fn_donee`.

**Ports**
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ld_valid  in  1  loader line valid.
- ld_data  in  WIDTH  loader line.
- ld_ready  out  1  host accepts a load line.
- fn_start  out  1  one-cycle start pulse to the function.
- fn_cnt_value  in  7  function's current line index.
- fn_line_in  out  WIDTH  input line for `fn_cnt_value`.
- fn_write_enable  in  1  function result strobe.
- fn_write_value  in  WIDTH  function result line.
- fn_donee  in  1  function done.
- out_valid  out  1  result line valid.
- out_data  out  WIDTH  result line.
- out_ready  in  1  downstream accepts.
- busy  out  1  state ≠ LOAD.
- err  out  3  sticky flags: {timeout, overflow, short}.
- err_clr  in  1  clears `err`.

## Operation

**Storage**
- Two LINES×WIDTH arrays: `in_buf` and `out_buf`.
- Three pointers, each 0..64: `ld_ptr`, `wr_ptr`, `rd_ptr`.
- Timeout counter sized to hold TIMEOUT.

**States: LOAD → START → RUN → DRAIN → LOAD**

- **LOAD:**
  - `ld_ready`=1.
  - Each cycle with `ld_valid`: `in_buf[ld_ptr]` ← `ld_data`, `ld_ptr`++.
  - The accept that makes `ld_ptr`=64 moves to START and clears `ld_ptr`.
- **START:**
  - `fn_start`=1 for exactly this cycle.
  - Clear `wr_ptr` and the timeout counter, then go to RUN.
- **RUN:**
  - **Capture:** `fn_write_enable` with `wr_ptr`<64 writes `out_buf[wr_ptr]` ← `fn_write_value` and increments `wr_ptr`.
  - **Overflow:** `fn_write_enable` with `wr_ptr`=64 drops the data and sets `err[1]`.
  - **Done:** `fn_donee` goes to DRAIN. A write in the same cycle is captured first. If the post-capture `wr_ptr` ≠ 64, set `err[0]`.
  - **Timeout:** the counter increments every RUN cycle without `fn_donee`. Reaching TIMEOUT sets `err[2]` and goes to DRAIN. If `fn_donee` arrives in the same cycle, done wins and `err[2]` is not set.
- **DRAIN:**
  - `out_valid`=1 and `out_data` = `out_buf[rd_ptr]`.
  - Each `out_valid`&&`out_ready` increments `rd_ptr`.
  - The 64th transfer clears `rd_ptr` and returns to LOAD.
  - Entries not written this pass hold their prior contents.

**Combinational outputs**
- `fn_line_in` = `in_buf[fn_cnt_value[5:0]]` when `fn_cnt_value` < 64, else 0. It is valid in every state.
- `fn_write_*` and `fn_donee` are ignored outside RUN.

**Error flags**
- `err` bits are sticky.
- `err_clr` clears them on the next edge.
- A set condition in the same cycle as `err_clr` wins.

## Timing

**Reset (`rst`=0, asynchronous)**
- State LOAD, all pointers 0, both buffers 0, timeout counter 0.
- Output values during reset: `ld_ready`=1, `fn_start`=0, `out_valid`=0, `busy`=0, `err`=0, `out_data`=0, `fn_line_in`=0.
- Reset in any state aborts the pass; nothing is emitted.

**Throughput and latency**
- LOAD takes one line per cycle, so the minimum load is 64 cycles.
- `fn_start` is high in the cycle after the 64th load accept.
- RUN is entered the following cycle.
- DRAIN is entered the cycle after `fn_donee` is sampled; `out_valid` rises on that same edge.
- With `out_ready` held high, DRAIN takes 64 cycles.
- LOAD is re-entered the cycle after the last transfer.

**Handshakes**
- `out_data` changes only after an accepted transfer.
- `out_valid` never drops in DRAIN until transfer 64.
- `ld_ready` is 0 outside LOAD, so `ld_valid` there is ignored.

## Test plan

- **Nominal pass:**
  - Stimulus: load lines `k`→`k*3+1`; the model function writes `~line` for each index 0..63, one per cycle, then `donee`.
  - Response: DRAIN emits `~(k*3+1)` in order, `err`=0, and `fn_start` is high exactly one cycle.
- **Index lookup:**
  - Stimulus: in RUN, `fn_cnt_value`=5 and then 64.
  - Response: `fn_line_in`=`in_buf[5]` and then 0.
- **Short and overflow:**
  - Stimulus: 60 writes then `donee` → response `err`=3'b001.
  - Stimulus: next pass, 66 writes then `donee` → response `err`=3'b011 (sticky), and only the first 64 lines are emitted.
- **Timeout:**
  - Stimulus: TIMEOUT=16, no `donee`.
  - Response: after 16 RUN cycles the host is in DRAIN with `err[2]`=1.
  - Stimulus: `donee` in exactly the 16th cycle → response `err[2]`=0.
- **Backpressure:**
  - Stimulus: toggle `out_ready` every 3 cycles.
  - Response: `out_data` holds stable while stalled, exactly 64 transfers occur in order, then `busy`=0.
- **Reset mid-RUN:**
  - Stimulus: assert `rst` low for 2 cycles after 30 writes.
  - Response: all outputs take their reset values asynchronously, state is LOAD, and the next 64 loads are accepted normally.

Source files
------------

// File: rtl/slice_stream_host.sv
// Host-side sequencer for the column-parity function: buffers a state image, starts the function,
// captures its result lines and streams them downstream.
module slice_stream_host #(
   parameter int unsigned LINES   = 64,
   parameter int unsigned WIDTH   = 25,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_valid,
   input  logic [WIDTH-1:0] ld_data,
   output logic             ld_ready,
   output logic             fn_start,
   input  logic [6:0]       fn_cnt_value,
   output logic [WIDTH-1:0] fn_line_in,
   input  logic             fn_write_enable,
   input  logic [WIDTH-1:0] fn_write_value,
   input  logic             fn_donee,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic [2:0]       err,
   input  logic             err_clr
);

   localparam int unsigned IdxW = $clog2(LINES);
   localparam int unsigned PtrW = $clog2(LINES + 1);
   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

   localparam logic [PtrW-1:0] PtrFull  = PtrW'(LINES);
   localparam logic [PtrW-1:0] PtrLast  = PtrW'(LINES - 1);
   localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT);
   localparam logic [6:0]      CntLimit = 7'(LINES);

   typedef enum logic [1:0] {StLoad, StStart, StRun, StDrain} state_e;

   state_e           state_q, state_d;
   logic [PtrW-1:0]  ld_ptr_q, ld_ptr_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [TmoW-1:0]  tmo_q, tmo_d;
   logic [2:0]       err_q, err_d;
   logic             fn_start_q, fn_start_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] in_buf_q  [LINES];
   logic [WIDTH-1:0] in_buf_d  [LINES];
   logic [WIDTH-1:0] out_buf_q [LINES];
   logic [WIDTH-1:0] out_buf_d [LINES];

   logic [2:0]       err_set;
   logic [PtrW-1:0]  wr_post;
   logic [TmoW-1:0]  tmo_inc;

   always_comb begin
      state_d     = state_q;
      ld_ptr_d    = ld_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      tmo_d       = tmo_q;
      fn_start_d  = 1'b0;
      out_valid_d = out_valid_q;
      in_buf_d    = in_buf_q;
      out_buf_d   = out_buf_q;
      err_set     = 3'b000;
      wr_post     = wr_ptr_q;
      tmo_inc     = tmo_q + 1'b1;

      unique case (state_q)
         StLoad: begin
            if (ld_valid) begin
               in_buf_d[ld_ptr_q[IdxW-1:0]] = ld_data;
               if (ld_ptr_q == PtrLast) begin
                  ld_ptr_d   = '0;
                  state_d    = StStart;
                  fn_start_d = 1'b1;
               end else begin
                  ld_ptr_d = ld_ptr_q + 1'b1;
               end
            end
         end
         StStart: begin
            wr_ptr_d = '0;
            tmo_d    = '0;
            state_d  = StRun;
         end
         StRun: begin
            if (fn_write_enable) begin
               if (wr_ptr_q < PtrFull) begin
                  out_buf_d[wr_ptr_q[IdxW-1:0]] = fn_write_value;
                  wr_post = wr_ptr_q + 1'b1;
               end else begin
                  err_set[1] = 1'b1;
               end
            end
            wr_ptr_d = wr_post;
            // Done is judged on the pointer after this cycle's capture and beats a timeout.
            if (fn_donee) begin
               state_d     = StDrain;
               out_valid_d = 1'b1;
               if (wr_post != PtrFull) begin
                  err_set[0] = 1'b1;
               end
            end else begin
               tmo_d = tmo_inc;
               if (tmo_inc == TmoLimit) begin
                  err_set[2]  = 1'b1;
                  state_d     = StDrain;
                  out_valid_d = 1'b1;
               end
            end
         end
         StDrain: begin
            if (out_ready) begin
               if (rd_ptr_q == PtrLast) begin
                  rd_ptr_d    = '0;
                  state_d     = StLoad;
                  out_valid_d = 1'b0;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         default: begin
            state_d     = StLoad;
            out_valid_d = 1'b0;
         end
      endcase

      err_d = (err_clr ? 3'b000 : err_q) | err_set;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StLoad;
         ld_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         tmo_q       <= '0;
         err_q       <= 3'b000;
         fn_start_q  <= 1'b0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < LINES; i++) begin
            in_buf_q[i]  <= '0;
            out_buf_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         ld_ptr_q    <= ld_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         fn_start_q  <= fn_start_d;
         out_valid_q <= out_valid_d;
         in_buf_q    <= in_buf_d;
         out_buf_q   <= out_buf_d;
      end
   end

   assign ld_ready   = (state_q == StLoad);
   assign busy       = (state_q != StLoad);
   assign fn_start   = fn_start_q;
   assign out_valid  = out_valid_q;
   assign err        = err_q;
   assign out_data   = out_valid_q ? out_buf_q[rd_ptr_q[IdxW-1:0]] : '0;
   assign fn_line_in = (fn_cnt_value < CntLimit) ? in_buf_q[fn_cnt_value[IdxW-1:0]] : '0;

endmodule

// File: tb/tb_slice_stream_host.sv
// Scoreboard bench for slice_stream_host: a bench-side function model writes results, the
// expected drain sequence is queued and compared as lines are accepted downstream.
module tb_slice_stream_host;

   localparam int TO = 80;

   logic        clk;
   logic        rst;
   logic        ld_valid;
   logic [24:0] ld_data;
   logic        ld_ready;
   logic        fn_start;
   logic [6:0]  fn_cnt_value;
   logic [24:0] fn_line_in;
   logic        fn_write_enable;
   logic [24:0] fn_write_value;
   logic        fn_donee;
   logic        out_valid;
   logic [24:0] out_data;
   logic        out_ready;
   logic        busy;
   logic [2:0]  err;
   logic        err_clr;

   slice_stream_host #(
      .LINES  (64),
      .WIDTH  (25),
      .TIMEOUT(TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ld_valid       (ld_valid),
      .ld_data        (ld_data),
      .ld_ready       (ld_ready),
      .fn_start       (fn_start),
      .fn_cnt_value   (fn_cnt_value),
      .fn_line_in     (fn_line_in),
      .fn_write_enable(fn_write_enable),
      .fn_write_value (fn_write_value),
      .fn_donee       (fn_donee),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
      .busy           (busy),
      .err            (err),
      .err_clr        (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks;
   int          n_fail;
   int          starts;
   int          starts_exp;
   logic [24:0] img     [64];
   logic [24:0] out_mem [64];
   logic [24:0] exp_q   [$];

   always @(negedge clk) if (fn_start === 1'b1) starts++;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_image(input int mul, input int add);
      for (int k = 0; k < 64; k++) begin
         img[k]   = 25'(k * mul + add);
         ld_valid = 1'b1;
         ld_data  = img[k];
         #1;
         if (k == 0 || k == 63) check_eq("ld_ready", 32'(ld_ready), 32'd1);
         tick();
      end
      ld_valid = 1'b0;
      check_eq("fn_start_hi", 32'(fn_start), 32'd1);
      check_eq("busy_start", 32'(busy), 32'd1);
      starts_exp++;
      tick();
      check_eq("fn_start_lo", 32'(fn_start), 32'd0);
   endtask

   task automatic queue_results();
      for (int k = 0; k < 64; k++) exp_q.push_back(out_mem[k]);
   endtask

   // Model function: writes ~line for index i, with ld_valid optionally held as noise.
   task automatic run_fn(input int nwr, input bit noise);
      ld_valid = noise;
      ld_data  = '1;
      for (int i = 0; i < nwr; i++) begin
         fn_cnt_value    = 7'(i);
         fn_write_enable = 1'b1;
         fn_write_value  = ~img[i % 64];
         #1;
         if (i < 64) begin
            check_eq("line_in", 32'(fn_line_in), 32'(img[i]));
            out_mem[i] = ~img[i];
         end
         tick();
      end
      fn_write_enable = 1'b0;
      fn_cnt_value    = 7'd64;
      #1;
      check_eq("line_in_oob", 32'(fn_line_in), 32'd0);
      check_eq("run_no_valid", 32'(out_valid), 32'd0);
      fn_donee = 1'b1;
      tick();
      fn_donee = 1'b0;
      ld_valid = 1'b0;
      check_eq("drain_entry", 32'(out_valid), 32'd1);
      queue_results();
   endtask

   task automatic run_tmo(input bit donee_last);
      for (int c = 1; c < TO; c++) tick();
      check_eq("tmo_still_run", 32'(out_valid), 32'd0);
      fn_donee = donee_last;
      tick();
      fn_donee = 1'b0;
      check_eq("tmo_drain", 32'(out_valid), 32'd1);
      queue_results();
   endtask

   task automatic drain(input bit bp);
      int          xf;
      bit          stalled;
      logic [24:0] prev;
      logic [24:0] exp;
      xf      = 0;
      stalled = 1'b0;
      prev    = '0;
      for (int c = 0; c < 400 && xf < 64; c++) begin
         out_ready = bp ? (((c / 3) % 2) == 1) : 1'b1;
         #1;
         if (out_valid !== 1'b1) begin
            check_eq("valid_hold", 32'(out_valid), 32'd1);
            break;
         end
         if (stalled) check_eq("stall_hold", 32'(out_data), 32'(prev));
         if (out_ready) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h1ffffff;
            check_eq("drain_data", 32'(out_data), 32'(exp));
            xf++;
         end
         stalled = !out_ready;
         prev    = out_data;
         tick();
      end
      out_ready = 1'b0;
      #1;
      check_eq("xfer_count", 32'(xf), 32'd64);
      check_eq("busy_after", 32'(busy), 32'd0);
      check_eq("valid_after", 32'(out_valid), 32'd0);
      check_eq("start_pulses", 32'(starts), 32'(starts_exp));
      exp_q.delete();
      tick();
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_eq("err_clr", 32'(err), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
      check_eq({tag, "_fn_start"}, 32'(fn_start), 32'd0);
      check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_err"}, 32'(err), 32'd0);
      check_eq({tag, "_out_data"}, 32'(out_data), 32'd0);
      check_eq({tag, "_line_in"}, 32'(fn_line_in), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0; n_fail = 0; starts = 0; starts_exp = 0;
      rst = 1'b0; ld_valid = 1'b0; ld_data = '0; fn_cnt_value = 7'd5;
      fn_write_enable = 1'b0; fn_write_value = '0; fn_donee = 1'b0;
      out_ready = 1'b0; err_clr = 1'b0;
      for (int k = 0; k < 64; k++) out_mem[k] = '0;
      #1;
      check_reset_outputs("rst");
      tick(); tick();
      rst = 1'b1;
      tick();

      // Nominal pass.
      load_image(3, 1);
      run_fn(64, 1'b0);
      check_eq("err_nominal", 32'(err), 32'd0);
      drain(1'b0);

      // Short pass with backpressure; lines 60..63 keep the previous pass's results.
      load_image(5, 7);
      run_fn(60, 1'b0);
      check_eq("err_short", 32'(err), 32'b001);
      drain(1'b1);

      // Overflow pass; loader noise during RUN/DRAIN must be ignored.
      load_image(1, 100);
      run_fn(66, 1'b1);
      check_eq("err_overflow", 32'(err), 32'b011);
      drain(1'b0);
      clear_err();

      // Timeout without donee.
      load_image(9, 2);
      run_tmo(1'b0);
      check_eq("err_timeout", 32'(err), 32'b100);
      drain(1'b1);
      clear_err();

      // Donee in the final timeout cycle: done wins, but nothing was written.
      load_image(11, 4);
      run_tmo(1'b1);
      check_eq("err_done_wins", 32'(err), 32'b001);
      drain(1'b0);

      // Reset in the middle of RUN after 30 writes.
      load_image(7, 3);
      for (int i = 0; i < 30; i++) begin
         fn_cnt_value    = 7'(i);
         fn_write_enable = 1'b1;
         fn_write_value  = ~img[i];
         tick();
      end
      fn_write_enable = 1'b0;
      fn_cnt_value    = 7'd5;
      rst             = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      tick(); tick();
      rst = 1'b1;
      for (int k = 0; k < 64; k++) out_mem[k] = '0;
      tick();
      load_image(13, 5);
      run_fn(64, 1'b0);
      check_eq("err_after_rst", 32'(err), 32'd0);
      drain(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
